// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exp mod n.
// Drives an external modular multiplier over a one-request-at-a-time en/valid handshake.
module modexp_ctrl #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             mul_en,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_n,
    input  logic [WIDTH-1:0] mul_r,
    input  logic             mul_valid
);

    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic signed [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
    localparam logic signed [IW-1:0] IDX_ONE = IW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SQR_REQ,
        SQR_WAIT,
        MUL_REQ,
        MUL_WAIT,
        DONE
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] base_q, base_q_d;
    logic [WIDTH-1:0] exp_q, exp_q_d;
    logic [WIDTH-1:0] n_q, n_q_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic signed [IW-1:0] idx, idx_d, idx_dec;
    logic err_q, err_q_d;
    logic bit_sel;

    logic [WIDTH-1:0] result_d;
    logic             done_d;
    logic             err_d;
    logic             mul_en_d;
    logic [WIDTH-1:0] mul_a_d;
    logic [WIDTH-1:0] mul_b_d;
    logic [WIDTH-1:0] mul_n_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
            exp_q  <= '0;
            n_q    <= '0;
            acc    <= '0;
            idx    <= '0;
            err_q  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            mul_en <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
            mul_n  <= '0;
        end else begin
            state  <= state_d;
            base_q <= base_q_d;
            exp_q  <= exp_q_d;
            n_q    <= n_q_d;
            acc    <= acc_d;
            idx    <= idx_d;
            err_q  <= err_q_d;
            result <= result_d;
            done   <= done_d;
            err    <= err_d;
            busy   <= (state_d != IDLE);
            mul_en <= mul_en_d;
            mul_a  <= mul_a_d;
            mul_b  <= mul_b_d;
            mul_n  <= mul_n_d;
        end
    end

    always_comb begin
        state_d  = state;
        base_q_d = base_q;
        exp_q_d  = exp_q;
        n_q_d    = n_q;
        acc_d    = acc;
        idx_d    = idx;
        err_q_d  = err_q;
        result_d = result;
        done_d   = 1'b0;
        err_d    = err;
        mul_en_d = 1'b0;
        mul_a_d  = mul_a;
        mul_b_d  = mul_b;
        mul_n_d  = mul_n;
        idx_dec  = idx - IDX_ONE;
        bit_sel  = exp_q[idx[IW-2:0]];

        // Multiplier operands are registered on the transition into a REQ state,
        // so they stay fixed through the whole wait for mul_valid.
        case (state)
            IDLE: begin
                if (start) begin
                    base_q_d = base;
                    exp_q_d  = exp;
                    n_q_d    = n;
                    if (n == '0 || base >= n) begin
                        err_q_d = 1'b1;
                        acc_d   = '0;
                        state_d = DONE;
                    end else begin
                        err_q_d = 1'b0;
                        idx_d   = IDX_TOP;
                        state_d = SCAN;
                    end
                end
            end

            SCAN: begin
                if (bit_sel) begin
                    acc_d = base_q;
                    idx_d = idx_dec;
                    if (idx_dec[IW-1]) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SQR_REQ;
                        mul_en_d = 1'b1;
                        mul_a_d  = base_q;
                        mul_b_d  = base_q;
                        mul_n_d  = n_q;
                    end
                end else if (idx == '0) begin
                    acc_d   = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    state_d = DONE;
                end else begin
                    idx_d = idx_dec;
                end
            end

            SQR_REQ: state_d = SQR_WAIT;

            SQR_WAIT: begin
                if (mul_valid) begin
                    acc_d = mul_r;
                    if (bit_sel) begin
                        state_d  = MUL_REQ;
                        mul_en_d = 1'b1;
                        mul_a_d  = mul_r;
                        mul_b_d  = base_q;
                        mul_n_d  = n_q;
                    end else begin
                        idx_d = idx_dec;
                        if (idx_dec[IW-1]) begin
                            state_d = DONE;
                        end else begin
                            state_d  = SQR_REQ;
                            mul_en_d = 1'b1;
                            mul_a_d  = mul_r;
                            mul_b_d  = mul_r;
                            mul_n_d  = n_q;
                        end
                    end
                end
            end

            MUL_REQ: state_d = MUL_WAIT;

            MUL_WAIT: begin
                if (mul_valid) begin
                    acc_d = mul_r;
                    idx_d = idx_dec;
                    if (idx_dec[IW-1]) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SQR_REQ;
                        mul_en_d = 1'b1;
                        mul_a_d  = mul_r;
                        mul_b_d  = mul_r;
                        mul_n_d  = n_q;
                    end
                end
            end

            DONE: begin
                done_d   = 1'b1;
                result_d = acc;
                err_d    = err_q;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with a latency-programmable mock modular multiplier.
module tb_modexp_ctrl;

    localparam int WIDTH = 256;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start;
    logic [WIDTH-1:0] base, exp, n, result;
    logic             done, err, busy, mul_en, mul_valid;
    logic [WIDTH-1:0] mul_a, mul_b, mul_n, mul_r;

    logic             mock_valid = 1'b0;
    logic [WIDTH-1:0] mock_r = '0;
    logic             glitch = 1'b0;
    logic [WIDTH-1:0] glitch_r = '0;
    assign mul_valid = mock_valid | glitch;
    assign mul_r     = glitch ? glitch_r : mock_r;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int en_count = 0, sq_count = 0;
    int en0 = 0, sq0 = 0;
    logic pend = 1'b0;
    int cnt = 0;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] rn, rb, want;

    modexp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base(base), .exp(exp), .n(n),
        .result(result), .done(done), .err(err), .busy(busy),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
        .mul_r(mul_r), .mul_valid(mul_valid)
    );

    // Mock multiplier: result is formed from the operands present on the valid cycle.
    always @(negedge clk) begin
        mock_valid = 1'b0;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                pend = 1'b0;
                mock_valid = 1'b1;
                if (mul_n == '0) begin
                    mock_r = '0;
                end else begin
                    prod = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
                    prod = prod % {{WIDTH{1'b0}}, mul_n};
                    mock_r = prod[WIDTH-1:0];
                end
            end
        end
        if (mul_en === 1'b1) begin
            pend = 1'b1;
            cnt = lat;
            en_count++;
            if (mul_a == mul_b) sq_count++;
        end
    end

    function automatic logic [WIDTH-1:0] modexp_ref(input logic [WIDTH-1:0] b, e, m);
        logic [2*WIDTH-1:0] r, s, mm;
        mm = {{WIDTH{1'b0}}, m};
        r = (2*WIDTH)'(1);
        s = {{WIDTH{1'b0}}, b};
        for (int i = 0; i < WIDTH; i++) begin
            if (e[i]) r = (r * s) % mm;
            s = (s * s) % mm;
        end
        return r[WIDTH-1:0];
    endfunction

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_op(input logic [WIDTH-1:0] b, e, m, input int l);
        @(negedge clk);
        lat = l;
        base = b;
        exp = e;
        n = m;
        start = 1'b1;
        en0 = en_count;
        sq0 = sq_count;
        cyc = 0;
        tick();
        start = 1'b0;
        check_val("busy_rise", WIDTH'(busy), WIDTH'(1));
    endtask

    task automatic wait_en(input string tag);
        while (mul_en !== 1'b1 && cyc < LIMIT) tick();
        check_val(tag, WIDTH'(mul_en), WIDTH'(1));
    endtask

    task automatic finish_op(input string tag, input logic [WIDTH-1:0] want_res,
                             input logic want_err, input int want_cyc, input int want_en);
        while (done !== 1'b1 && cyc < LIMIT) tick();
        check_val({tag, "_done"}, WIDTH'(done), WIDTH'(1));
        check_val({tag, "_result"}, result, want_res);
        check_val({tag, "_err"}, WIDTH'(err), WIDTH'(want_err));
        check_val({tag, "_cycles"}, WIDTH'(cyc), WIDTH'(want_cyc));
        check_val({tag, "_mul_en"}, WIDTH'(en_count - en0), WIDTH'(want_en));
        check_val({tag, "_busy_fall"}, WIDTH'(busy), WIDTH'(0));
        tick();
        check_val({tag, "_done_pulse"}, WIDTH'(done), WIDTH'(0));
        check_val({tag, "_result_hold"}, result, want_res);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] b, e, m, input int l,
                          input logic [WIDTH-1:0] want_res, input logic want_err,
                          input int want_cyc, input int want_en);
        start_op(b, e, m, l);
        finish_op(tag, want_res, want_err, want_cyc, want_en);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        exp = '0;
        n = '0;
        repeat (3) @(negedge clk);
        check_val("rst_result", result, '0);
        check_val("rst_done", WIDTH'(done), '0);
        check_val("rst_err", WIDTH'(err), '0);
        check_val("rst_busy", WIDTH'(busy), '0);
        check_val("rst_mul_en", WIDTH'(mul_en), '0);
        check_val("rst_mul_a", mul_a, '0);
        check_val("rst_mul_b", mul_b, '0);
        check_val("rst_mul_n", mul_n, '0);
        rst = 1'b0;

        // 5^3 mod 23 = 125 mod 23 = 10: scan 255, two requests of 1+3, done 2 later
        run_op("basic", WIDTH'(5), WIDTH'(3), WIDTH'(23), 3, WIDTH'(10), 1'b0, 265, 2);
        check_val("basic_squares", WIDTH'(sq_count - sq0), WIDTH'(1));

        start_op(WIDTH'(9), '0, WIDTH'(23), 1);
        repeat (5) tick();
        check_val("hold_prev", result, WIDTH'(10));
        finish_op("exp0", WIDTH'(1), 1'b0, 258, 0);

        run_op("exp0_n1", '0, '0, WIDTH'(1), 1, '0, 1'b0, 258, 0);
        run_op("exp1", WIDTH'(5), WIDTH'(1), WIDTH'(23), 1, WIDTH'(5), 1'b0, 258, 0);
        run_op("base_gt_n", WIDTH'(7), WIDTH'(3), WIDTH'(5), 1, '0, 1'b1, 2, 0);
        run_op("base_eq_n", WIDTH'(23), WIDTH'(3), WIDTH'(23), 1, '0, 1'b1, 2, 0);
        run_op("n_zero", WIDTH'(3), WIDTH'(3), '0, 1, '0, 1'b1, 2, 0);

        for (int i = 0; i < WIDTH / 32; i++) begin
            rn[i*32 +: 32] = $urandom;
            rb[i*32 +: 32] = $urandom;
        end
        rn[WIDTH-1] = 1'b1;
        rn[0] = 1'b1;
        rb = rb % rn;
        want = modexp_ref(rb, '1, rn);
        run_op("full_l1", rb, '1, rn, 1, want, 1'b0, 1 + 510 * 2 + 2, 510);
        check_val("full_l1_squares", WIDTH'(sq_count - sq0), WIDTH'(255));
        run_op("full_l7", rb, '1, rn, 7, want, 1'b0, 1 + 510 * 8 + 2, 510);
        check_val("full_l7_squares", WIDTH'(sq_count - sq0), WIDTH'(255));

        // Reset while a multiply is outstanding; its late mul_valid must be ignored.
        start_op(WIDTH'(5), WIDTH'(3), WIDTH'(23), 3);
        wait_en("rst_sqr_req");
        tick();
        wait_en("rst_mul_req");
        tick();
        rst = 1'b1;
        tick();
        check_val("rst_mid_busy", WIDTH'(busy), '0);
        check_val("rst_mid_mul_en", WIDTH'(mul_en), '0);
        rst = 1'b0;
        repeat (4) tick();
        check_val("stale_busy", WIDTH'(busy), '0);
        check_val("stale_done", WIDTH'(done), '0);
        run_op("after_rst", WIDTH'(5), WIDTH'(3), WIDTH'(23), 3, WIDTH'(10), 1'b0, 265, 2);

        // Spurious valid in SQR_REQ, then a start pulse during SQR_WAIT.
        start_op(WIDTH'(5), WIDTH'(3), WIDTH'(23), 3);
        wait_en("glitch_sqr_req");
        check_val("sqr_mul_a", mul_a, WIDTH'(5));
        check_val("sqr_mul_b", mul_b, WIDTH'(5));
        check_val("sqr_mul_n", mul_n, WIDTH'(23));
        glitch_r = WIDTH'(7);
        glitch = 1'b1;
        tick();
        glitch = 1'b0;
        base = WIDTH'(2);
        exp = WIDTH'(1);
        n = WIDTH'(11);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_en("glitch_mul_req");
        check_val("mul_mul_a", mul_a, WIDTH'(2));
        check_val("mul_mul_b", mul_b, WIDTH'(5));
        finish_op("glitch", WIDTH'(10), 1'b0, 265, 2);
        repeat (3) tick();
        check_val("idle_result", result, WIDTH'(10));
        check_val("idle_done", WIDTH'(done), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
